// File: rtl/apb_pkg.sv
// Shared definitions for the APB subsystem: master FSM state encoding
// and default bus widths.
package apb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_if.sv
// Internal APB3 bus between apb_master and apb_slave_mem (no pslverr/pstrb).
// master modport: drives psel/penable/pwrite/paddr/pwdata, samples pready.
// slave modport : samples the request, drives pready/prdata.
// The master does not consume prdata; the top taps it from the bus directly.
interface apb_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input pready);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, prdata);
endinterface

// File: rtl/apb_master.sv
// APB master: IDLE/SETUP/ACCESS FSM bridging a transfer-request interface
// onto the internal APB bus. The request is captured on every entry into
// SETUP and held through ACCESS regardless of later input changes.
// Ports: pclk, presetn (sync, active-high), transfer, read_write (1=write),
//        apb_read_paddr, apb_write_paddr, apb_write_data, bus (master modport).
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  apb_if.master             bus
);
  apb_state_e        r_state, w_next;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (transfer) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (bus.pready) w_next = transfer ? SETUP : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_state  <= IDLE;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_next;
      // Entry into SETUP (from IDLE or back-to-back from ACCESS) latches a new request.
      if (w_next == SETUP) begin
        r_pwrite <= read_write;
        r_paddr  <= read_write ? apb_write_paddr : apb_read_paddr;
        r_pwdata <= apb_write_data;
      end
    end
  end

  assign bus.psel    = (r_state != IDLE);
  assign bus.penable = (r_state == ACCESS);
  assign bus.pwrite  = r_pwrite;
  assign bus.paddr   = r_paddr;
  assign bus.pwdata  = r_pwdata;
endmodule

// File: rtl/apb_slave_mem.sv
// APB slave: 2**ADDR_W x DATA_W register file. Writes commit and reads
// update the held prdata register on the completing ACCESS edge.
// Optional macro APB_WAIT_STATE_EN: one wait state per transfer via a
// registered pready; otherwise pready = psel & penable (zero-wait).
// Ports: pclk, presetn (sync, active-high), bus (slave modport).
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic pclk,
  input  logic presetn,
  apb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_prdata;
  logic              w_access;
  logic              w_done;

  assign w_access = bus.psel & bus.penable;

`ifdef APB_WAIT_STATE_EN
  logic r_pready;
  // Low in the first ACCESS cycle, high in the second, cleared after completion.
  always_ff @(posedge pclk) begin
    if (presetn) r_pready <= 1'b0;
    else         r_pready <= w_access & ~r_pready;
  end
  assign bus.pready = r_pready;
`else
  assign bus.pready = w_access;
`endif

  assign w_done = w_access & bus.pready;

  always_ff @(posedge pclk) begin
    if (presetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_prdata <= '0;
    end else if (w_done) begin
      if (bus.pwrite) r_mem[bus.paddr] <= bus.pwdata;
      else            r_prdata         <= r_mem[bus.paddr];
    end
  end

  assign bus.prdata = r_prdata;
endmodule

// File: rtl/apb_topmodule.sv
// APB subsystem top: apb_master + apb_slave_mem joined by an internal apb_if.
// Optional macro APB_WAIT_STATE_EN (see apb_slave_mem).
// Ports: pclk, presetn (sync, active-high), transfer, read_write (1=write),
//        apb_read_paddr, apb_write_paddr, apb_write_data,
//        prdata (held last read data), pready (internal PREADY).
module apb_topmodule
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  output logic [DATA_W-1:0] prdata,
  output logic              pready
);
  apb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus ();

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_master (
    .pclk            (pclk),
    .presetn         (presetn),
    .transfer        (transfer),
    .read_write      (read_write),
    .apb_read_paddr  (apb_read_paddr),
    .apb_write_paddr (apb_write_paddr),
    .apb_write_data  (apb_write_data),
    .bus             (u_bus.master)
  );

  apb_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (u_bus.slave)
  );

  assign prdata = u_bus.prdata;
  assign pready = u_bus.pready;
endmodule

// File: tb/tb_apb_topmodule.sv
// Self-checking bench for apb_topmodule: randomized transfers checked
// against a transaction-level memory/prdata model.
module tb_apb_topmodule;
`ifdef APB_WAIT_STATE_EN
  localparam int WAITS = 1;
`else
  localparam int WAITS = 0;
`endif

  logic       pclk = 1'b0;
  logic       presetn = 1'b1;
  logic       transfer = 1'b0;
  logic       read_write = 1'b0;
  logic [7:0] apb_read_paddr = '0;
  logic [7:0] apb_write_paddr = '0;
  logic [7:0] apb_write_data = '0;
  logic [7:0] prdata;
  logic       pready;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [256];
  logic [7:0] model_prdata;

  always #5 pclk = ~pclk;

  apb_topmodule dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .transfer        (transfer),
    .read_write      (read_write),
    .apb_read_paddr  (apb_read_paddr),
    .apb_write_paddr (apb_write_paddr),
    .apb_write_data  (apb_write_data),
    .prdata          (prdata),
    .pready          (pready)
  );

  // Probe of the internal bus
  apb_if #(.ADDR_W(8), .DATA_W(8)) mon ();
  assign mon.psel    = dut.u_bus.psel;
  assign mon.penable = dut.u_bus.penable;
  assign mon.pwrite  = dut.u_bus.pwrite;
  assign mon.paddr   = dut.u_bus.paddr;
  assign mon.pwdata  = dut.u_bus.pwdata;
  assign mon.pready  = dut.u_bus.pready;
  assign mon.prdata  = dut.u_bus.prdata;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_prdata = 8'h00;
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One transfer. Entry: 1 time unit after an edge, DUT idle or in the final
  // ACCESS cycle of a previous held transfer. With hold=1 it returns in the
  // final ACCESS cycle so the next call chains back-to-back.
  task automatic do_xfer(input bit rw, input logic [7:0] waddr, input logic [7:0] raddr,
                         input logic [7:0] wdata, input bit hold);
    int waits;
    bit done;
    logic [7:0] a;
    transfer = 1'b1; read_write = rw;
    apb_write_paddr = waddr; apb_read_paddr = raddr; apb_write_data = wdata;
    tick();
    checks++;
    if (mon.psel !== 1'b1 || mon.penable !== 1'b0) begin
      failures++;
      $display("FAIL setup_phase: psel=%b penable=%b required 1/0", mon.psel, mon.penable);
    end
    checks++;
    if (prdata !== model_prdata) begin
      failures++;
      $display("FAIL prdata_at_setup: got %h required %h", prdata, model_prdata);
    end
    // Scramble inputs: the captured request must stay put.
    read_write = 1'($urandom); apb_write_paddr = 8'($urandom);
    apb_read_paddr = 8'($urandom); apb_write_data = 8'($urandom);
    transfer = hold;
    waits = 0; done = 0;
    for (int n = 0; n < 5 && !done; n++) begin
      tick();
      a = rw ? waddr : raddr;
      checks++;
      if (mon.psel !== 1'b1 || mon.penable !== 1'b1 || mon.pwrite !== rw ||
          mon.paddr !== a || (rw && mon.pwdata !== wdata)) begin
        failures++;
        $display("FAIL access_phase: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h required 1/1/%b/%h/%h",
                 mon.psel, mon.penable, mon.pwrite, mon.paddr, mon.pwdata, rw, a, wdata);
      end
      if (pready === 1'b1) done = 1;
      else waits++;
    end
    checks++;
    if (!done || waits != WAITS) begin
      failures++;
      $display("FAIL wait_states: done=%0d waits=%0d required 1/%0d", done, waits, WAITS);
    end
    if (rw) model_mem[waddr] = wdata;
    else    model_prdata = model_mem[raddr];
    if (!hold) begin
      tick();
      checks++;
      if (mon.psel !== 1'b0 || mon.penable !== 1'b0 || pready !== 1'b0) begin
        failures++;
        $display("FAIL back_to_idle: psel=%b pen=%b pready=%b required 0/0/0",
                 mon.psel, mon.penable, pready);
      end
      checks++;
      if (prdata !== model_prdata) begin
        failures++;
        $display("FAIL prdata_after: got %h required %h", prdata, model_prdata);
      end
      checks++;
      if (dut.u_slave.r_mem[waddr] !== model_mem[waddr]) begin
        failures++;
        $display("FAIL mem_entry[%h]: got %h required %h", waddr,
                 dut.u_slave.r_mem[waddr], model_mem[waddr]);
      end
    end
  endtask

  task automatic test_reset();
    presetn = 1'b1; transfer = 1'b1;
    repeat (2) tick();
    model_reset();
    checks++;
    if (prdata !== 8'h00 || pready !== 1'b0 || mon.psel !== 1'b0 || mon.penable !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: prdata=%h pready=%b psel=%b pen=%b required 00/0/0/0",
               prdata, pready, mon.psel, mon.penable);
    end
    checks++;
    if (dut.u_slave.r_mem[8'h10] !== 8'h00 || dut.u_slave.r_mem[8'hFF] !== 8'h00) begin
      failures++;
      $display("FAIL reset_mem: [10]=%h [ff]=%h required 00/00",
               dut.u_slave.r_mem[8'h10], dut.u_slave.r_mem[8'hFF]);
    end
    transfer = 1'b0; presetn = 1'b0;
    tick();
  endtask

  task automatic test_write();
    do_xfer(1'b1, 8'h10, 8'($urandom), 8'hA5, 1'b0);
  endtask

  task automatic test_read();
    do_xfer(1'b0, 8'($urandom), 8'h10, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) begin
      read_write = 1'($urandom); apb_read_paddr = 8'($urandom);
      tick();
      checks++;
      if (prdata !== 8'hA5 || mon.psel !== 1'b0) begin
        failures++;
        $display("FAIL read_hold: prdata=%h psel=%b required a5/0", prdata, mon.psel);
      end
    end
  endtask

  task automatic test_addr_mux();
    do_xfer(1'b1, 8'h20, 8'h55, 8'h3C, 1'b0);
    do_xfer(1'b0, 8'h55, 8'h20, 8'($urandom), 1'b0);
    checks++;
    if (prdata !== 8'h3C || dut.u_slave.r_mem[8'h55] !== 8'h00) begin
      failures++;
      $display("FAIL addr_mux: prdata=%h mem[55]=%h required 3c/00",
               prdata, dut.u_slave.r_mem[8'h55]);
    end
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 8'h00, 8'($urandom), 8'h01, 1'b1);
    do_xfer(1'b0, 8'($urandom), 8'h00, 8'($urandom), 1'b0);
    checks++;
    if (prdata !== 8'h01) begin
      failures++;
      $display("FAIL back_to_back_raw: prdata=%h required 01", prdata);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 30; i++)
      do_xfer(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              8'($urandom), (i != 29) && 1'($urandom));
    for (int i = 0; i < 16; i++) begin
      a = 8'(i);
      checks++;
      if (dut.u_slave.r_mem[a] !== model_mem[a]) begin
        failures++;
        $display("FAIL random_mem[%h]: got %h required %h", a, dut.u_slave.r_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    transfer = 1'b1; read_write = 1'b1;
    apb_write_paddr = 8'h30; apb_write_data = 8'h77;
    tick();
    transfer = 1'b0;
    seen = 0;
    for (int n = 0; n < 5 && !seen; n++) begin
      tick();
      if (pready === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_reach_access: pready never 1");
    end
    presetn = 1'b1;
    tick();
    presetn = 1'b0;
    model_reset();
    checks++;
    if (mon.psel !== 1'b0 || dut.u_slave.r_mem[8'h30] !== 8'h00 || prdata !== 8'h00 ||
        dut.u_slave.r_mem[8'h10] !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: psel=%b mem[30]=%h mem[10]=%h prdata=%h required 0/00/00/00",
               mon.psel, dut.u_slave.r_mem[8'h30], dut.u_slave.r_mem[8'h10], prdata);
    end
    // Subsystem is usable again after reset.
    do_xfer(1'b1, 8'h30, 8'h00, 8'h5A, 1'b0);
    do_xfer(1'b0, 8'h00, 8'h30, 8'h00, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_addr_mux();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_topmodule.md
# apb_topmodule

Self-contained APB subsystem: an APB master FSM bridging a simple transfer-request interface to an internal APB bus, and an 8-bit-addressed 256×8 register-file slave on that bus. It serves as the top-level APB test vehicle and the reference integration of master and slave. All logic runs on one clock with a synchronous reset.

## Interface
Parameters:
- ADDR_W, 8, address width (memory depth 2**ADDR_W)
- DATA_W, 8, data width

Ports:
- pclk  input  1  clock; all state updates on rising edge
- presetn  input  1  synchronous active-high reset (1 = reset, sampled on pclk rising edge); port name kept per codebase
- transfer  input  1  request; 1 starts or continues transfers
- read_write  input  1  1 = write, 0 = read
- apb_read_paddr  input  ADDR_W  read address
- apb_write_paddr  input  ADDR_W  write address
- apb_write_data  input  DATA_W  write data
- prdata  output  DATA_W  last read data (registered, held)
- pready  output  1  slave ready, internal APB PREADY brought out

## Operation
- Internal bus: psel, penable, pwrite, paddr, pwdata, pready, prdata per APB3 (no pslverr, no pstrb).
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE: psel=0, penable=0. transfer=1 -> SETUP.
  - SETUP: psel=1, penable=0. Always -> ACCESS.
  - ACCESS: psel=1, penable=1. pready=0 -> stay. pready=1 & transfer=1 -> SETUP (back-to-back). pready=1 & transfer=0 -> IDLE.
- Request capture: on every transition into SETUP, register pwrite<=read_write, paddr<=(read_write ? apb_write_paddr : apb_read_paddr), pwdata<=apb_write_data. Held stable through SETUP and ACCESS regardless of input changes.
- Slave: mem[0..255] of DATA_W.
  - Write: psel&penable&pwrite&pready -> mem[paddr]<=pwdata.
  - Read: psel&penable&!pwrite&pready -> prdata<=mem[paddr].
- prdata holds its value until the next completed read; writes do not modify it.
- Dropping transfer during SETUP/ACCESS does not abort the transfer in flight; it completes, then IDLE.

## Timing
- Reset (presetn=1 at edge): state=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, prdata=0, pready=0, all mem entries = 0. Reset overrides any transfer in progress; no write commits in the reset cycle.
- Zero-wait (default): pready is combinational = psel&penable. Transfer occupies SETUP + ACCESS = 2 cycles after the IDLE cycle sampling transfer=1.
- Write commits at the ACCESS-cycle edge; prdata updates at the ACCESS-cycle edge of a read (visible the following cycle).
- Back-to-back: consecutive transfers take 2 cycles each, no IDLE between them.
- Read-after-write to same address in back-to-back transfers returns the new data.

## Configuration
- APB_WAIT_STATE_EN defined: slave inserts exactly one wait state; pready is registered, 0 in the first ACCESS cycle, 1 in the second; transfer = 3 cycles. pready returns to 0 after completion.
- Undefined: zero-wait behaviour as above.

## Structure
- Shared package apb_pkg: state enum (IDLE/SETUP/ACCESS), ADDR_W/DATA_W default constants.
- Sub-modules: apb_master (FSM and request capture) and apb_slave_mem (memory, pready, prdata); apb_topmodule only instantiates and wires them.

## Test plan
- Reset: presetn=1 for 2 cycles -> prdata=0, pready=0, internal psel/penable=0.
- Write: transfer=1, read_write=1, apb_write_paddr=0x10, apb_write_data=0xA5 for 2 cycles -> SETUP then ACCESS, pready=1 in ACCESS, mem[0x10]=0xA5.
- Read: transfer=1, read_write=0, apb_read_paddr=0x10 -> after ACCESS, prdata=0xA5 and holds after transfer=0.
- Address mux: write 0x3C to 0x20 with apb_read_paddr=0x55; read 0x20 with apb_write_paddr=0x55 -> prdata=0x3C, mem[0x55] unchanged (0).
- Back-to-back: transfer held 1, write 0x01->0x00 then read 0x00 -> no IDLE between, prdata=0x01.
- Reset mid-transfer: presetn=1 during ACCESS of write 0x77->0x30 -> IDLE next cycle, mem[0x30]=0, prdata=0; with APB_WAIT_STATE_EN repeat write/read -> pready low first ACCESS cycle, 3-cycle transfers.
